// File: rtl/config_frame_fsm_pkg.sv
// Shared configuration constants and the sequencer state type.
package cfg_pkg;

  localparam int          FRAME_BITS_PER_ROW = 32;
  localparam int          DESYNC_FLAG        = 20;
  localparam logic [31:0] SYNC_WORD          = 32'hFAB0_FAB1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_ADDR = 2'd1,
    GET_DATA = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/config_frame_fsm_if.sv
// Config word stream in, frame/row write signals out.
// Timeout exists only when CONFIG_FRAME_TIMEOUT_EN is defined.
interface config_frame_fsm_if #(
  parameter int RowSelectWidth = 5
);
  import cfg_pkg::*;

  logic [FRAME_BITS_PER_ROW-1:0] ConfigWriteData;
  logic                          ConfigWriteStrobe;
  logic [31:0]                   FrameAddressRegister;
  logic [RowSelectWidth-1:0]     RowSelect;
  logic [FRAME_BITS_PER_ROW-1:0] RowWriteData;
  logic                          RowWriteStrobe;
  logic                          LongFrameStrobe;
  logic                          Synced;
`ifdef CONFIG_FRAME_TIMEOUT_EN
  logic                          Timeout;
`endif

  // Config block side: drives the word stream.
  modport master (
    output ConfigWriteData, ConfigWriteStrobe,
    input  FrameAddressRegister, RowSelect, RowWriteData,
           RowWriteStrobe, LongFrameStrobe, Synced
`ifdef CONFIG_FRAME_TIMEOUT_EN
    , input Timeout
`endif
  );

  // Sequencer side.
  modport slave (
    input  ConfigWriteData, ConfigWriteStrobe,
    output FrameAddressRegister, RowSelect, RowWriteData,
           RowWriteStrobe, LongFrameStrobe, Synced
`ifdef CONFIG_FRAME_TIMEOUT_EN
    , output Timeout
`endif
  );

endinterface

// File: rtl/config_frame_fsm_idle_timer.sv
// Idle-cycle timer: down-counter reloaded on clear, expired is a
// one-cycle pulse on the TimeoutCycles-th consecutive enabled cycle.
module cfg_idle_timer #(
  parameter int TimeoutCycles = 1024
) (
  input  logic CLK,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);
  localparam int            W    = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [W-1:0]  LOAD = W'(TimeoutCycles - 1);

  logic [W-1:0] cnt_q;

  assign expired = enable && (cnt_q == '0);

  // Reload on clear or expiry, otherwise count down while enabled.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset)                 cnt_q <= LOAD;
    else if (clear || expired) cnt_q <= LOAD;
    else if (enable)           cnt_q <= cnt_q - 1'b1;
  end

endmodule

// File: rtl/config_frame_fsm.sv
// Config frame sequencer: sync lock, frame address latch, row distribution.
// Optional idle timeout enabled by CONFIG_FRAME_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | unsynced, waiting for SYNC_WORD
// GET_ADDR | synced, next non-sync word is a frame address or desync
// GET_DATA | distributing NumberOfRows data words to rows
module config_frame_fsm
  import cfg_pkg::*;
#(
  parameter int NumberOfRows   = 16,
  parameter int RowSelectWidth = 5,
  parameter int TimeoutCycles  = 1024
) (
  input  logic                CLK,
  input  logic                reset,
  config_frame_fsm_if.slave   bus
);
  localparam logic [RowSelectWidth-1:0] LAST_ROW = RowSelectWidth'(NumberOfRows - 1);
  localparam logic [RowSelectWidth-1:0] NO_ROW   = '1;

  cfg_state_e                    state_q, state_d;
  logic [RowSelectWidth-1:0]     cnt_q, cnt_d;
  logic [31:0]                   far_q, far_d;
  logic [RowSelectWidth-1:0]     rs_q, rs_d;
  logic [FRAME_BITS_PER_ROW-1:0] rwd_q, rwd_d;
  logic                          rws_q, rws_d;
  logic                          lfs_q, lfs_d;
  logic                          synced_q;
  logic                          to_q, to_d;
  logic                          timer_expired;

  logic                          strb;
  logic [FRAME_BITS_PER_ROW-1:0] word;

  assign strb = bus.ConfigWriteStrobe;
  assign word = bus.ConfigWriteData;

`ifdef CONFIG_FRAME_TIMEOUT_EN
  cfg_idle_timer #(.TimeoutCycles(TimeoutCycles)) u_idle_timer (
    .CLK     (CLK),
    .reset   (reset),
    .enable  ((state_q != IDLE) && !strb),
    .clear   ((state_q == IDLE) || strb),
    .expired (timer_expired)
  );
  assign bus.Timeout = to_q;
`else
  assign timer_expired = 1'b0;
`endif

  // State, row counter and all registered outputs.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      far_q    <= '0;
      rs_q     <= NO_ROW;
      rwd_q    <= '0;
      rws_q    <= 1'b0;
      lfs_q    <= 1'b0;
      synced_q <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      far_q    <= far_d;
      rs_q     <= rs_d;
      rwd_q    <= rwd_d;
      rws_q    <= rws_d;
      lfs_q    <= lfs_d;
      synced_q <= (state_d != IDLE);
      to_q     <= to_d;
    end
  end

  // Next-state and next-output decode; pulses default low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    far_d   = far_q;
    rs_d    = rs_q;
    rwd_d   = rwd_q;
    rws_d   = 1'b0;
    lfs_d   = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (strb && word == SYNC_WORD) state_d = GET_ADDR;
      end
      GET_ADDR: begin
        if (strb && word != SYNC_WORD) begin
          rs_d = NO_ROW;
          if (word[DESYNC_FLAG]) begin
            state_d = IDLE;
          end else begin
            far_d   = word;
            cnt_d   = '0;
            state_d = GET_DATA;
          end
        end
      end
      GET_DATA: begin
        // Data words are never interpreted as sync or desync.
        if (strb) begin
          rwd_d = word;
          rs_d  = cnt_q;
          rws_d = 1'b1;
          if (cnt_q == LAST_ROW) begin
            lfs_d   = 1'b1;
            cnt_d   = '0;
            state_d = GET_ADDR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (timer_expired) begin
      state_d = IDLE;
      cnt_d   = '0;
      rs_d    = NO_ROW;
      to_d    = 1'b1;
    end
  end

  assign bus.FrameAddressRegister = far_q;
  assign bus.RowSelect            = rs_q;
  assign bus.RowWriteData         = rwd_q;
  assign bus.RowWriteStrobe       = rws_q;
  assign bus.LongFrameStrobe      = lfs_q;
  assign bus.Synced               = synced_q;

endmodule
